// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and its hazard/stall controller.
// master = datapath side (reports status, consumes controls)
// slave  = controller side (consumes status, drives controls)
interface pipeline_hazard_ctrl_if;
    // status from the pipeline
    logic        imem_resp;
    logic        dmem_resp;
    logic        dmem_need;
    logic        br_taken;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    // controls back to the pipeline
    logic        imem_read;
    logic        dmem_req_en;
    logic        pc_load;
    logic        if_id_load;
    logic        id_ex_load;
    logic        ex_mem_load;
    logic        mem_wb_load;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        pc_sel_target;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output imem_resp, dmem_resp, dmem_need, br_taken, ex_mem_read,
               ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  imem_read, dmem_req_en, pc_load, if_id_load, id_ex_load,
               ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush,
               ex_mem_flush, pc_sel_target, state, stall_cnt, bubble_cnt,
               flush_cnt
    );

    modport slave (
        input  imem_resp, dmem_resp, dmem_need, br_taken, ex_mem_read,
               ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output imem_read, dmem_req_en, pc_load, if_id_load, id_ex_load,
               ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush,
               ex_mem_flush, pc_sel_target, state, stall_cnt, bubble_cnt,
               flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline. Holds an early memory
// response while waiting for the other one, inserts a load-use bubble,
// flushes on taken branches, and counts stall/bubble/flush cycles.
module pipeline_hazard_ctrl (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_hazard_ctrl_if.slave       hif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_HELD = 2'd1,
        D_HELD = 2'd2
    } state_t;

    state_t st;

    logic i_done, d_done, i_ok, d_ok, advance, hazard;
    logic do_flush, do_bubble;

    // response bookkeeping and load-use detection
    always_comb begin
        i_done    = (st == I_HELD);
        d_done    = (st == D_HELD);
        i_ok      = hif.imem_resp | i_done;
        d_ok      = ~hif.dmem_need | hif.dmem_resp | d_done;
        advance   = i_ok & d_ok;
        hazard    = hif.ex_mem_read & (hif.ex_rd != 5'd0) &
                    ((hif.id_uses_rs1 & (hif.ex_rd == hif.id_rs1)) |
                     (hif.id_uses_rs2 & (hif.ex_rd == hif.id_rs2)));
        // branch wins over the bubble: the bubbled instruction is squashed anyway
        do_flush  = advance & hif.br_taken;
        do_bubble = advance & ~hif.br_taken & hazard;
    end

    // stage-register controls; forced low while reset is asserted
    always_comb begin
        hif.imem_read     = 1'b0;
        hif.dmem_req_en   = 1'b0;
        hif.pc_load       = 1'b0;
        hif.if_id_load    = 1'b0;
        hif.id_ex_load    = 1'b0;
        hif.ex_mem_load   = 1'b0;
        hif.mem_wb_load   = 1'b0;
        hif.if_id_flush   = 1'b0;
        hif.id_ex_flush   = 1'b0;
        hif.ex_mem_flush  = 1'b0;
        hif.pc_sel_target = 1'b0;
        if (rst) begin
            hif.imem_read   = ~i_done;
            hif.dmem_req_en = hif.dmem_need & ~d_done;
            if (advance) begin
                hif.pc_load     = ~do_bubble;
                hif.if_id_load  = ~do_bubble;
                hif.id_ex_load  = 1'b1;
                hif.ex_mem_load = 1'b1;
                hif.mem_wb_load = 1'b1;
                hif.if_id_flush   = do_flush;
                hif.id_ex_flush   = do_flush | do_bubble;
                hif.ex_mem_flush  = do_flush;
                hif.pc_sel_target = do_flush;
            end
        end
    end

    assign hif.state = st;

    // response-hold FSM and saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st             <= RUN;
            hif.stall_cnt  <= 16'd0;
            hif.bubble_cnt <= 16'd0;
            hif.flush_cnt  <= 16'd0;
        end else begin
            case (st)
                RUN: begin
                    if (hif.imem_resp & ~d_ok)
                        st <= I_HELD;
                    else if (hif.dmem_need & hif.dmem_resp & ~i_ok)
                        st <= D_HELD;
                end
                I_HELD, D_HELD: begin
                    if (advance)
                        st <= RUN;
                end
                default: st <= RUN;
            endcase

            if (!advance && hif.stall_cnt != 16'hFFFF)
                hif.stall_cnt <= hif.stall_cnt + 16'd1;
            if (do_bubble && hif.bubble_cnt != 16'hFFFF)
                hif.bubble_cnt <= hif.bubble_cnt + 16'd1;
            if (do_flush && hif.flush_cnt != 16'hFFFF)
                hif.flush_cnt <= hif.flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed corner sequences,
// and random traffic against a response-tracking reference model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hif ();

    pipeline_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    int checks = 0;
    int errors = 0;

    // reference model: which memory responses have already been received for
    // the instruction group that has not yet moved, plus event tallies
    bit m_have_i, m_have_d;
    int m_stall, m_bub, m_fl;

    typedef struct {
        logic       imem_resp, dmem_resp, dmem_need, br_taken, ex_mem_read;
        logic [4:0] ex_rd, rs1, rs2;
        logic       u1, u2;
        logic [10:0] exp_ctl;   // {loads[4:0], flushes[2:0], sel, imem_read, dmem_req_en}
        logic [1:0] exp_state;  // state after the edge
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] dut_ctl();
        return {hif.pc_load, hif.if_id_load, hif.id_ex_load, hif.ex_mem_load,
                hif.mem_wb_load, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush,
                hif.pc_sel_target, hif.imem_read, hif.dmem_req_en};
    endfunction

    function automatic bit m_hazard();
        if (!hif.ex_mem_read || hif.ex_rd == 0) return 0;
        return (hif.id_uses_rs1 && hif.ex_rd == hif.id_rs1) ||
               (hif.id_uses_rs2 && hif.ex_rd == hif.id_rs2);
    endfunction

    function automatic bit m_adv();
        bit got_i, got_d;
        got_i = m_have_i || hif.imem_resp;
        got_d = !hif.dmem_need || m_have_d || hif.dmem_resp;
        return got_i && got_d;
    endfunction

    function automatic logic [10:0] model_ctl();
        logic [4:0] ld;
        logic [2:0] fl;
        logic sel;
        ld = 0; fl = 0; sel = 0;
        if (m_adv()) begin
            if (hif.br_taken) begin ld = 5'b11111; fl = 3'b111; sel = 1; end
            else if (m_hazard()) begin ld = 5'b00111; fl = 3'b010; end
            else ld = 5'b11111;
        end
        return {ld, fl, sel, !m_have_i, hif.dmem_need && !m_have_d};
    endfunction

    function automatic logic [1:0] model_state();
        return m_have_i ? 2'd1 : (m_have_d ? 2'd2 : 2'd0);
    endfunction

    // advance the model by one clock using the currently driven inputs
    task automatic model_step();
        if (m_adv()) begin
            if (hif.br_taken) begin if (m_fl < 65535) m_fl++; end
            else if (m_hazard()) begin if (m_bub < 65535) m_bub++; end
            m_have_i = 0;
            m_have_d = 0;
        end else begin
            if (m_stall < 65535) m_stall++;
            if (hif.imem_resp) m_have_i = 1;
            if (hif.dmem_need && hif.dmem_resp) m_have_d = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ir, input logic dr, input logic dn, input logic br,
                          input logic emr, input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic u1, input logic u2);
        hif.imem_resp = ir;  hif.dmem_resp = dr; hif.dmem_need = dn;
        hif.br_taken = br;   hif.ex_mem_read = emr; hif.ex_rd = rd;
        hif.id_rs1 = r1;     hif.id_rs2 = r2;
        hif.id_uses_rs1 = u1; hif.id_uses_rs2 = u2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        m_have_i = 0; m_have_d = 0; m_stall = 0; m_bub = 0; m_fl = 0;
        #1;
        chk("reset_ctl", 32'(dut_ctl()), 32'd0);
        chk("reset_state", 32'(hif.state), 32'd0);
        chk("reset_cnt", {hif.stall_cnt, hif.bubble_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // inputs must already be driven; checks controls, clocks, checks state/counters
    task automatic run_cycle();
        #1;
        chk("rand_ctl", 32'(dut_ctl()), 32'(model_ctl()));
        tick();
        chk("rand_state", 32'(hif.state), 32'(model_state()));
        chk("rand_stall", 32'(hif.stall_cnt), 32'(m_stall));
        chk("rand_bubble", 32'(hif.bubble_cnt), 32'(m_bub));
        chk("rand_flush", 32'(hif.flush_cnt), 32'(m_fl));
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic dn, input logic br,
                                input logic emr, input logic [4:0] rd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic u1, input logic u2,
                                input logic [10:0] ctl, input logic [1:0] ns);
        vec_t v;
        v.imem_resp = ir; v.dmem_resp = dr; v.dmem_need = dn; v.br_taken = br;
        v.ex_mem_read = emr; v.ex_rd = rd; v.rs1 = r1; v.rs2 = r2; v.u1 = u1; v.u2 = u2;
        v.exp_ctl = ctl; v.exp_state = ns;
        return v;
    endfunction

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            ir dr dn br emr rd r1 r2 u1 u2   {ld, fl, sel, ird, dreq}
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, {5'b11111, 3'b000, 3'b010}, 2'd0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {5'b00000, 3'b000, 3'b010}, 2'd0);
        vecs[2]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, {5'b00000, 3'b000, 3'b011}, 2'd1);
        vecs[3]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, {5'b00000, 3'b000, 3'b011}, 2'd2);
        vecs[4]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, {5'b11111, 3'b000, 3'b011}, 2'd0);
        vecs[5]  = mk(1, 0, 0, 0, 1, 5, 1, 5, 0, 1, {5'b00111, 3'b010, 3'b010}, 2'd0);
        vecs[6]  = mk(1, 0, 0, 1, 1, 5, 1, 5, 0, 1, {5'b11111, 3'b111, 3'b110}, 2'd0);
        vecs[7]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, {5'b11111, 3'b000, 3'b010}, 2'd0);
        vecs[8]  = mk(1, 0, 0, 0, 1, 7, 7, 3, 0, 1, {5'b11111, 3'b000, 3'b010}, 2'd0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 7, 7, 7, 1, 1, {5'b11111, 3'b000, 3'b010}, 2'd0);
        vecs[10] = mk(0, 0, 0, 1, 1, 7, 7, 7, 1, 1, {5'b00000, 3'b000, 3'b010}, 2'd0);
        vecs[11] = mk(1, 1, 1, 0, 1, 9, 9, 2, 1, 0, {5'b00111, 3'b010, 3'b011}, 2'd0);

        #2;
        chk("por_state", 32'(hif.state), 32'd0);

        // single-cycle vector table, each from a fresh reset
        for (int i = 0; i < 12; i++) begin
            do_reset();
            set_in(vecs[i].imem_resp, vecs[i].dmem_resp, vecs[i].dmem_need, vecs[i].br_taken,
                   vecs[i].ex_mem_read, vecs[i].ex_rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].u1, vecs[i].u2);
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(dut_ctl()), 32'(vecs[i].exp_ctl));
            tick();
            chk($sformatf("vec%0d_state", i), 32'(hif.state), 32'(vecs[i].exp_state));
        end

        // imem early, dmem arrives three cycles later
        do_reset();
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ih_c0_loads", 32'(hif.pc_load | hif.mem_wb_load), 32'd0);
        tick();
        chk("ih_c1_state", 32'(hif.state), 32'd1);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("ih_c%0d_imem_read", c), 32'(hif.imem_read), 32'd0);
            chk($sformatf("ih_c%0d_loads", c), 32'(hif.pc_load | hif.id_ex_load), 32'd0);
            tick();
            chk($sformatf("ih_c%0d_state", c + 1), 32'(hif.state), 32'd1);
        end
        @(negedge clk);
        set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ih_c3_imem_read", 32'(hif.imem_read), 32'd0);
        chk("ih_c3_loads", 32'({hif.pc_load, hif.if_id_load, hif.id_ex_load,
                                 hif.ex_mem_load, hif.mem_wb_load}), 32'h1f);
        tick();
        chk("ih_c4_state", 32'(hif.state), 32'd0);
        chk("ih_stall_cnt", 32'(hif.stall_cnt), 32'd3);

        // load-use bubble, then same hazard with a taken branch
        do_reset();
        set_in(1, 0, 0, 0, 1, 5, 0, 5, 0, 1);
        #1;
        chk("haz_pc_if", 32'({hif.pc_load, hif.if_id_load}), 32'd0);
        chk("haz_id_ex", 32'({hif.id_ex_load, hif.id_ex_flush}), 32'd3);
        tick();
        chk("haz_bubble_cnt", 32'(hif.bubble_cnt), 32'd1);
        @(negedge clk);
        hif.br_taken = 1'b1;
        #1;
        chk("br_ctl", 32'(dut_ctl()), 32'({5'b11111, 3'b111, 3'b110}));
        tick();
        chk("br_flush_cnt", 32'(hif.flush_cnt), 32'd1);
        chk("br_bubble_cnt", 32'(hif.bubble_cnt), 32'd1);

        // reset in the middle of a D_HELD stall
        do_reset();
        set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("dh_state", 32'(hif.state), 32'd2);
        @(negedge clk);
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("dh_rst_state", 32'(hif.state), 32'd0);
        chk("dh_rst_cnt", 32'(hif.stall_cnt), 32'd0);
        chk("dh_rst_ctl", 32'(dut_ctl()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_have_i = 0; m_have_d = 0; m_stall = 0; m_bub = 0; m_fl = 0;
        #1;
        chk("dh_rel_dreq", 32'({hif.imem_read, hif.dmem_req_en}), 32'd3);
        tick();
        chk("dh_rel_state", 32'(hif.state), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_cycle();
        end

        // stall counter saturation
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_stall_ffff", 32'(hif.stall_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_stall_hold", 32'(hif.stall_cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL run on a single clock `clk`; reset is asynchronous and active-low on port `rst`.
REQ-002 Ports SHALL be as follows (`name  direction  width  meaning`):
- `clk  in  1`  rising-edge clock
- `rst  in  1`  async active-low reset
- `imem_resp  in  1`  instruction memory response valid this cycle
- `dmem_resp  in  1`  data memory response valid this cycle
- `dmem_need  in  1`  MEM-stage instruction is a load/store
- `br_taken  in  1`  MEM-stage branch/jump resolved taken
- `ex_mem_read  in  1`  EX-stage instruction is a load
- `ex_rd  in  5`  EX-stage destination register
- `id_rs1, id_rs2  in  5 each`  ID-stage source registers
- `id_uses_rs1, id_uses_rs2  in  1 each`  ID instruction reads rs1/rs2
- `imem_read  out  1`  instruction fetch request
- `dmem_req_en  out  1`  enable for data memory request
- `pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each`  stage register loads
- `if_id_flush, id_ex_flush, ex_mem_flush  out  1 each`  load bubble (control word zeroed) instead of data
- `pc_sel_target  out  1`  PC mux selects branch target
- `state  out  2`  FSM state: RUN=0, I_HELD=1, D_HELD=2
- `stall_cnt, bubble_cnt, flush_cnt  out  16 each`  saturating performance counters

Function
REQ-003 i_ok = imem_resp | i_done; d_ok = ~dmem_need | dmem_resp | d_done; advance = i_ok & d_ok (combinational).
REQ-004 imem_read SHALL equal ~i_done; dmem_req_en SHALL equal dmem_need & ~d_done.
REQ-005 FSM transitions:
- RUN -> I_HELD when imem_resp & ~d_ok
- RUN -> D_HELD when dmem_need & dmem_resp & ~i_ok
- I_HELD/D_HELD -> RUN on advance
- otherwise hold
REQ-006 i_done = (state==I_HELD); d_done = (state==D_HELD); the state SHALL NOT record both held at once.
REQ-007 hazard = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-008 With advance=0, all five loads, all flushes and pc_sel_target SHALL be 0.
REQ-009 With advance=1 & br_taken, outputs SHALL be:
- all five loads =1
- if_id_flush = id_ex_flush = ex_mem_flush = 1
- pc_sel_target = 1
- hazard ignored (branch priority)
REQ-010 With advance=1 & ~br_taken & hazard, outputs SHALL be:
- pc_load = if_id_load = 0
- id_ex_load = 1 with id_ex_flush = 1
- ex_mem_load = mem_wb_load = 1
REQ-011 With advance=1 & neither condition, all loads SHALL be 1, all flushes 0, and pc_sel_target 0.
REQ-012 Flush outputs SHALL only assert together with the matching load; latency from input change to load/flush output is 0 cycles (combinational), and the state update takes effect at the next edge.
REQ-013 Counters SHALL behave as follows:
- stall_cnt +1 per cycle with advance=0
- bubble_cnt +1 per REQ-010 cycle
- flush_cnt +1 per REQ-009 cycle
- each saturates at 16'hFFFF, no wrap
REQ-014 br_taken or hazard arriving while advance=0 SHALL have no effect until the cycle advance=1; the inputs are sampled then.
REQ-015 Simultaneous imem_resp and dmem_resp in any state SHALL produce advance=1 and a transition to RUN.

Reset
REQ-016 While rst=0, the block SHALL immediately and asynchronously set:
- state = RUN
- all counters = 0
- all loads, flushes, pc_sel_target, imem_read and dmem_req_en = 0
REQ-017 Reset asserted mid-stall SHALL discard held-response state; after release, operation restarts in RUN with no responses held.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- imem_resp=1, dmem_need=0, no hazard -> all loads=1, flushes=0, state stays RUN.
- imem_resp=1 at cycle 0, dmem_need=1, dmem_resp=1 at cycle 3 -> state=I_HELD cycles 1-3, loads=0 cycles 0-2, imem_read=0 cycles 1-3, advance at cycle 3, stall_cnt=3.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, responses ready -> pc_load=if_id_load=0, id_ex_flush=1, bubble_cnt=1.
- Same hazard plus br_taken=1 -> all loads=1, three flushes=1, pc_sel_target=1, flush_cnt=1, bubble_cnt unchanged.
- ex_rd=0 matching id_rs1=0 -> no bubble.
- stall_cnt preloaded to FFFF by 65535 stall cycles, then 1 more stall -> remains FFFF.
- rst dropped while state=D_HELD -> state=0 and counters=0 immediately.
